// File: rtl/ysyx_23060096_regfile_sb.sv
// ysyx_23060096_regfile_sb
// Multi-port integer register file with a busy-bit scoreboard for the NPC
// core. Decode reads operands through NREAD combinational ports and uses
// o_rd_ready to spot read-after-write hazards before issuing.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rd_addr/o_rd_data   NREAD packed read ports (port k at slice k)
//   o_rd_ready            per-port "operand not pending" flag
//   i_wb0_*               ALU write-back port
//   i_wb1_*               LSU write-back port (wins on address collision)
//   i_iss_en/i_iss_addr   issue: mark destination register busy
//   o_busy_cnt            number of registers currently marked busy
module ysyx_23060096_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREAD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NREAD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NREAD-1:0]            o_rd_ready,
  input  logic                        i_wb0_en,
  input  logic [ADDR_WIDTH-1:0]       i_wb0_addr,
  input  logic [DATA_WIDTH-1:0]       i_wb0_data,
  input  logic                        i_wb1_en,
  input  logic [ADDR_WIDTH-1:0]       i_wb1_addr,
  input  logic [DATA_WIDTH-1:0]       i_wb1_data,
  input  logic                        i_iss_en,
  input  logic [ADDR_WIDTH-1:0]       i_iss_addr,
  output logic [ADDR_WIDTH:0]         o_busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH:0]   r_busy_cnt;

  logic                  w_wb0_ok;
  logic                  w_wb1_ok;
  logic                  w_iss_ok;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_busy_cnt_nxt;

  // With a hardwired zero register, anything aimed at r0 is simply dropped.
  assign w_wb0_ok = i_wb0_en && !((ZERO_REG != 0) && (i_wb0_addr == '0));
  assign w_wb1_ok = i_wb1_en && !((ZERO_REG != 0) && (i_wb1_addr == '0));
  assign w_iss_ok = i_iss_en && !((ZERO_REG != 0) && (i_iss_addr == '0));

  // Next scoreboard state: clears first, then the issue set, so a producer
  // issued in the same cycle its predecessor writes back stays pending.
  // The population count is taken on the next state so o_busy_cnt tracks
  // the busy bits with no extra cycle of latency.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb0_ok) w_busy_nxt[i_wb0_addr] = 1'b0;
    if (w_wb1_ok) w_busy_nxt[i_wb1_addr] = 1'b0;
    if (w_iss_ok) w_busy_nxt[i_iss_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Storage and scoreboard update. wb1 is written after wb0 so it wins
  // when both target the same register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wb0_ok) r_rf[i_wb0_addr] <= i_wb0_data;
      if (w_wb1_ok) r_rf[i_wb1_addr] <= i_wb1_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  // Read ports: stored value, optionally overridden by a same-cycle
  // write-back (wb1 checked last so it takes precedence), and finally
  // forced to zero/ready for r0 when it is hardwired.
  always_comb begin
    o_rd_data  = '0;
    o_rd_ready = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [ADDR_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_rdy;
      w_addr = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_data = r_rf[w_addr];
      w_rdy  = !r_busy[w_addr];
      if (BYPASS != 0) begin
        if (i_wb0_en && (i_wb0_addr == w_addr)) begin
          w_data = i_wb0_data;
          w_rdy  = 1'b1;
        end
        if (i_wb1_en && (i_wb1_addr == w_addr)) begin
          w_data = i_wb1_data;
          w_rdy  = 1'b1;
        end
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
        w_rdy  = 1'b1;
      end
      o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
      o_rd_ready[k] = w_rdy;
    end
  end

endmodule
